// File: rtl/car_ctrl_cond.sv
// car_ctrl_cond: synchronizes and debounces the raw stalk, brake and hazard inputs,
//    latches the hazard button into an emergency level, and resolves left/right conflicts.
// Latency: a raw edge reaches left/right/brake after DB_CYCLES+3 edges and emergency after DB_CYCLES+4.
// Backpressure: none. Outputs are plain levels that the downstream LED controller samples every cycle.
//
// Ports:
//    clk, reset (async, active-high)
//    sw_left, sw_right, sw_brake, btn_hazard : raw asynchronous switch inputs
//    left, right, brake, emergency           : registered conditioned levels
//    evt                                     : registered, high in any cycle where an output took a new value
//
// Optional build macro TURN_TIMEOUT_EN: each turn output auto-cancels after TURN_TIMEOUT cycles
//    continuously high. It then stays locked off until that side's debounced input goes low.

module car_ctrl_cond #(
   parameter int DB_CYCLES    = 4,
   parameter int TURN_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic sw_left,
   input  logic sw_right,
   input  logic sw_brake,
   input  logic btn_hazard,
   output logic left,
   output logic right,
   output logic brake,
   output logic emergency,
   output logic evt
);

   localparam int             CW      = $clog2(DB_CYCLES + 1);
   // The counter flips the state on the edge where it would reach DB_CYCLES,
   // so the compare value is one less than that count.
   localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

   // Input bit order: 0 = left, 1 = right, 2 = brake, 3 = hazard.
   logic [3:0]    raw;
   logic [3:0]    sync1_q, sync2_q;
   logic [3:0]    db_q, db_d;
   logic [CW-1:0] cnt_q [4];
   logic [CW-1:0] cnt_d [4];

   logic          hz_prev_q, hz_prev_d;
   logic          hz_latch_q, hz_latch_d;

   logic          left_q, left_d;
   logic          right_q, right_d;
   logic          brake_q, brake_d;
   logic          emergency_q, emergency_d;
   logic          evt_q, evt_d;

   assign raw = {btn_hazard, sw_brake, sw_right, sw_left};

   // Debounce. Any agreeing sample restarts the count, so only a run of
   // DB_CYCLES consecutive differing samples can flip the debounced state.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               db_d[i] = ~db_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Hazard press detect. Only the 0->1 transition toggles the latch, so a
   // held button or a release has no effect.
   always_comb begin
      hz_prev_d  = db_q[3];
      hz_latch_d = hz_latch_q ^ (db_q[3] & ~hz_prev_q);
   end

`ifdef TURN_TIMEOUT_EN
   localparam int            TW       = $clog2(TURN_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TURN_TIMEOUT - 1);

   logic [TW-1:0] tmr_l_q, tmr_l_d, tmr_r_q, tmr_r_d;
   logic          lock_l_q, lock_l_d, lock_r_q, lock_r_d;
   logic          fire_l, fire_r;

   // Timers count the cycles each turn output has already been high. The
   // forced drop lands on the edge where the output would start its
   // (TURN_TIMEOUT+1)th cycle, which gives exactly TURN_TIMEOUT high cycles.
   always_comb begin
      fire_l   = left_q  && (tmr_l_q == TMO_LAST);
      fire_r   = right_q && (tmr_r_q == TMO_LAST);
      tmr_l_d  = left_q  ? tmr_l_q + 1'b1 : '0;
      tmr_r_d  = right_q ? tmr_r_q + 1'b1 : '0;
      // A lock is held only while that side's debounced input stays high.
      lock_l_d = fire_l | (lock_l_q & db_q[0]);
      lock_r_d = fire_r | (lock_r_q & db_q[1]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmr_l_q  <= '0;
         tmr_r_q  <= '0;
         lock_l_q <= 1'b0;
         lock_r_q <= 1'b0;
      end else begin
         tmr_l_q  <= tmr_l_d;
         tmr_r_q  <= tmr_r_d;
         lock_l_q <= lock_l_d;
         lock_r_q <= lock_r_d;
      end
   end

   always_comb begin
      left_d  = db_q[0] & ~db_q[1] & ~lock_l_q & ~fire_l;
      right_d = db_q[1] & ~db_q[0] & ~lock_r_q & ~fire_r;
   end
`else
   logic unused_tmo;
   assign unused_tmo = (TURN_TIMEOUT > 0);

   // Both stalk contacts high is a conflict and blanks both sides.
   always_comb begin
      left_d  = db_q[0] & ~db_q[1];
      right_d = db_q[1] & ~db_q[0];
   end
`endif

   always_comb begin
      brake_d     = db_q[2];
      emergency_d = hz_latch_q;
      evt_d       = ({left_d, right_d, brake_d, emergency_d} !=
                     {left_q, right_q, brake_q, emergency_q});
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         hz_prev_q   <= 1'b0;
         hz_latch_q  <= 1'b0;
         left_q      <= 1'b0;
         right_q     <= 1'b0;
         brake_q     <= 1'b0;
         emergency_q <= 1'b0;
         evt_q       <= 1'b0;
      end else begin
         sync1_q     <= raw;
         sync2_q     <= sync1_q;
         db_q        <= db_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         hz_prev_q   <= hz_prev_d;
         hz_latch_q  <= hz_latch_d;
         left_q      <= left_d;
         right_q     <= right_d;
         brake_q     <= brake_d;
         emergency_q <= emergency_d;
         evt_q       <= evt_d;
      end
   end

   assign left      = left_q;
   assign right     = right_q;
   assign brake     = brake_q;
   assign emergency = emergency_q;
   assign evt       = evt_q;

endmodule

// File: tb/tb_car_ctrl_cond.sv
// tb_car_ctrl_cond: exercises car_ctrl_cond with DB_CYCLES=4 and TURN_TIMEOUT=64.
// Latency: the bench samples outputs 1 time unit after each rising edge.
// Backpressure: not applicable.

module tb_car_ctrl_cond;

   logic clk = 1'b0;
   logic reset;
   logic sw_left, sw_right, sw_brake, btn_hazard;
   logic left, right, brake, emergency, evt;

   int   n_total  = 0;
   int   n_passed = 0;
   int   evt_cnt  = 0;
   int   both_err = 0;

   always #5 clk = ~clk;

   car_ctrl_cond #(.DB_CYCLES(4), .TURN_TIMEOUT(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_left    (sw_left),
      .sw_right   (sw_right),
      .sw_brake   (sw_brake),
      .btn_hazard (btn_hazard),
      .left       (left),
      .right      (right),
      .brake      (brake),
      .emergency  (emergency),
      .evt        (evt)
   );

   // in  = {btn_hazard, sw_brake, sw_right, sw_left}
   // exp = {left, right, brake, emergency}
   typedef struct packed {
      logic [3:0] in;
      logic [3:0] exp;
   } vec_t;

   vec_t       vecs [8];
   logic [3:0] sb [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // One rising edge, then sample away from it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (evt === 1'b1) evt_cnt++;
      if (left === 1'b1 && right === 1'b1) both_err++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      vecs[0] = '{in: 4'b0001, exp: 4'b1000};
      vecs[1] = '{in: 4'b0101, exp: 4'b1010};
      vecs[2] = '{in: 4'b0010, exp: 4'b0100};
      vecs[3] = '{in: 4'b0011, exp: 4'b0000};
      vecs[4] = '{in: 4'b1100, exp: 4'b0011};
      vecs[5] = '{in: 4'b0100, exp: 4'b0011};
      vecs[6] = '{in: 4'b1010, exp: 4'b0100};
      vecs[7] = '{in: 4'b0000, exp: 4'b0000};

      reset = 1'b1;
      {btn_hazard, sw_brake, sw_right, sw_left} = 4'b0000;
      ticks(3);
      check("outputs_in_reset", {27'd0, left, right, brake, emergency, evt}, 32'd0);
      reset = 1'b0;
      evt_cnt = 0;
      tick();
      check("outputs_first_edge", {27'd0, left, right, brake, emergency, evt}, 32'd0);
      ticks(49);
      check("idle_outputs", {28'd0, left, right, brake, emergency}, 32'd0);
      check("idle_evt_count", evt_cnt, 0);

      // Table: hold each input pattern long enough to settle, then compare.
      for (int v = 0; v < 8; v++) begin
         logic [3:0] e;
         {btn_hazard, sw_brake, sw_right, sw_left} = vecs[v].in;
         sb.push_back(vecs[v].exp);
         ticks(12);
         e = sb.pop_front();
         check($sformatf("vec%0d_outputs", v), {28'd0, left, right, brake, emergency}, {28'd0, e});
         check($sformatf("vec%0d_evt_settled", v), {31'd0, evt}, 32'd0);
      end

      // Clean left step: exact latency and a single evt pulse.
      evt_cnt = 0;
      sw_left = 1'b1;
      ticks(6);
      check("left_edge6", {31'd0, left}, 32'd0);
      tick();
      check("left_edge7", {31'd0, left}, 32'd1);
      check("left_evt_edge7", {31'd0, evt}, 32'd1);
      check("left_right_low", {31'd0, right}, 32'd0);
      tick();
      check("left_evt_edge8", {31'd0, evt}, 32'd0);
      check("left_evt_count", evt_cnt, 1);
      sw_left = 1'b0;
      ticks(12);
      check("left_release", {31'd0, left}, 32'd0);

      // Brake bounce: 3-cycle highs with 1-cycle lows never get through.
      begin
         int bad;
         bad = 0;
         for (int p = 0; p < 10; p++) begin
            sw_brake = 1'b1;
            for (int k = 0; k < 3; k++) begin tick(); if (brake !== 1'b0) bad++; end
            sw_brake = 1'b0;
            tick(); if (brake !== 1'b0) bad++;
         end
         sw_brake = 1'b1;
         for (int k = 0; k < 6; k++) begin tick(); if (brake !== 1'b0) bad++; end
         check("brake_bounce_blocked", bad, 0);
         tick();
         check("brake_after_bounce_edge7", {31'd0, brake}, 32'd1);
         sw_brake = 1'b0;
         ticks(12);
      end

      // Hazard press, hold, release, press again.
      btn_hazard = 1'b1;
      ticks(7);
      check("hz_on_edge7", {31'd0, emergency}, 32'd0);
      tick();
      check("hz_on_edge8", {31'd0, emergency}, 32'd1);
      ticks(12);
      btn_hazard = 1'b0;
      ticks(15);
      check("hz_held_after_release", {31'd0, emergency}, 32'd1);
      btn_hazard = 1'b1;
      ticks(7);
      check("hz_off_edge7", {31'd0, emergency}, 32'd1);
      tick();
      check("hz_off_edge8", {31'd0, emergency}, 32'd0);
      btn_hazard = 1'b0;
      ticks(12);

      // Stalk conflict, then release of the right contact.
      evt_cnt  = 0;
      sw_left  = 1'b1;
      sw_right = 1'b1;
      ticks(15);
      check("conflict_outputs", {30'd0, left, right}, 32'd0);
      check("conflict_no_evt", evt_cnt, 0);
      sw_right = 1'b0;
      ticks(6);
      check("conflict_release_edge6", {31'd0, left}, 32'd0);
      tick();
      check("conflict_release_edge7", {31'd0, left}, 32'd1);
      sw_left = 1'b0;
      ticks(12);

      // Reset while the hazard is on and the button is still held.
      btn_hazard = 1'b1;
      ticks(10);
      check("midreset_hz_on", {31'd0, emergency}, 32'd1);
      reset = 1'b1;
      #1;
      check("midreset_async_clear", {27'd0, left, right, brake, emergency, evt}, 32'd0);
      ticks(2);
      reset = 1'b0;
      ticks(7);
      check("midreset_hz_edge7", {31'd0, emergency}, 32'd0);
      tick();
      check("midreset_hz_edge8", {31'd0, emergency}, 32'd1);
      btn_hazard = 1'b0;
      ticks(12);

      // Long right-turn hold.
      sw_right = 1'b1;
      ticks(7);
      check("right_on_edge7", {31'd0, right}, 32'd1);
`ifdef TURN_TIMEOUT_EN
      begin
         int hi;
         int drop_evt;
         hi = 1;
         drop_evt = 0;
         for (int k = 0; k < 100; k++) begin
            tick();
            if (right === 1'b1) hi++;
            else if (drop_evt == 0) drop_evt = evt ? 1 : 2;
         end
         check("timeout_high_cycles", hi, 64);
         check("timeout_drop_evt", drop_evt, 1);
         sw_right = 1'b0;
         ticks(10);
         sw_right = 1'b1;
         ticks(7);
         check("timeout_rearm", {31'd0, right}, 32'd1);
      end
`else
      ticks(100);
      check("right_no_timeout", {31'd0, right}, 32'd1);
`endif
      sw_right = 1'b0;
      ticks(12);
      check("right_release", {31'd0, right}, 32'd0);
      check("never_left_and_right", both_err, 0);

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/car_ctrl_cond.md
Name: car_ctrl_cond

Overview:
- Input conditioner that sits directly upstream of the car tail-light LED controller.
- Takes raw driver switches (turn stalk, brake pedal switch, hazard push-button) and synchronizes and debounces them.
- Converts the momentary hazard button into a latched emergency level and resolves left/right conflicts.
- Drives clean left/right/brake/emergency levels into the LED controller, plus a change-event pulse.

Parameters:
- DB_CYCLES, 4: consecutive differing synchronized samples required before a debounced value flips (legal range 2..255).
- TURN_TIMEOUT, 64: cycles a turn output may stay continuously high before auto-cancel. Used only with TURN_TIMEOUT_EN.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- sw_left, input, 1: raw left stalk level (asynchronous, may bounce).
- sw_right, input, 1: raw right stalk level.
- sw_brake, input, 1: raw brake switch level.
- btn_hazard, input, 1: raw momentary hazard push-button.
- left, output, 1: conditioned left-turn request.
- right, output, 1: conditioned right-turn request.
- brake, output, 1: conditioned brake level.
- emergency, output, 1: latched hazard state.
- evt, output, 1: one-cycle pulse when any of the four outputs changes.

Behaviour:
- Reset (asynchronous, active-high):
  - Clears all sync flops, debounce counters and debounced states.
  - Clears the hazard latch, the output registers and any timers.
  - left, right, brake, emergency and evt are all 0 during reset and on the first edge after reset.
- Synchronizer: a 2-flop chain per raw input.
- Debouncer, one per input:
  - Holds a debounced state db_x and a counter of width ceil(log2(DB_CYCLES+1)).
  - On each edge where sync_x != db_x, the counter increments.
  - When the count would reach DB_CYCLES, db_x flips and the counter clears.
  - Any edge where sync_x == db_x clears the counter.
  - Consequently, bounces shorter than DB_CYCLES cycles never reach db_x.
- Hazard latch:
  - A rising edge of db_hazard (previous 0, current 1) toggles hz_latch.
  - A falling edge has no effect.
  - Holding the button does not re-toggle.
- Output decode, registered:
  - emergency <= hz_latch
  - brake <= db_brake
  - left <= db_left & ~db_right
  - right <= db_right & ~db_left
  - Both stalk inputs high is a conflict: left = right = 0.
  - Outputs are not one-hot: left/right with brake is legal, and emergency is independent of the other outputs.
- Latency:
  - A clean raw edge reaches left/right/brake after DB_CYCLES+3 rising edges (2 sync, DB_CYCLES debounce, 1 output). Default: 7.
  - A hazard press reaches emergency in DB_CYCLES+4 edges, because of the extra edge-detect register.
- evt:
  - Registered; high for exactly one cycle, namely the cycle in which any output takes a new value.
  - If outputs change on consecutive edges, evt stays high across those cycles.
- Reset mid-operation:
  - All state is lost and the hazard turns off.
  - A button still held after reset debounces to 1, producing a rising edge, so emergency turns on at DB_CYCLES+4 edges after reset release.
- Simultaneous events:
  - Hazard toggle and stalk/brake changes on the same edge are handled independently.
  - A stalk change from left straight to right passes through one or more cycles of left = right = 0, or a conflict window, but never left = right = 1.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - Each side has a counter (ceil(log2(TURN_TIMEOUT+1)) bits).
  - The counter increments every cycle its turn output is 1 and clears when the output is 0.
  - When it reaches TURN_TIMEOUT, that output is forced to 0 and a per-side lock flag is set.
  - The lock clears only when that side's db input goes 0; the side can then re-assert normally.
  - evt pulses on the forced drop.
  - Locks clear on reset.
- Not defined: no timers or locks; turn outputs follow the decode indefinitely.

Test Plan:
- Reset release with all inputs 0 -> all outputs 0 and evt never pulses for 50 cycles.
- sw_left steps 0->1 clean, DB_CYCLES=4 -> left=1 on edge 7 after the step, evt=1 for exactly that cycle, right=0.
- sw_brake bounces: 3-cycle highs separated by 1-cycle lows for 40 cycles, then held high -> brake stays 0 during the bounce and goes 1 seven edges after the last low.
- btn_hazard pressed for 20 cycles, released, pressed again -> emergency 0→1 at edge 8 after the first press, stays 1 through the release, returns to 0 eight edges after the second press.
- sw_left and sw_right both held 1 -> left=right=0. Releasing sw_right -> left=1 seven edges later.
- TURN_TIMEOUT_EN defined, TURN_TIMEOUT=64, sw_right held -> right high for exactly 64 cycles, then 0 with an evt pulse. After sw_right is released for 10 cycles and re-pressed, right returns to 1.
